// File: rtl/bss_pkg.sv
// Shared constants for the borrow-select subtractor: state encodings,
// default geometry and the helpers that size the chunk index.
package bss_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    localparam int BSS_WIDTH = 16;
    localparam int BSS_CHUNK = 4;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/borrow_select_chunk.sv
// Combinational CHUNK-bit dual subtractor: the same slice evaluated with
// borrow-in 0 and borrow-in 1 so the caller only has to pick one.
module borrow_select_chunk
    import bss_pkg::*;
#(
    parameter int CHUNK = BSS_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] d0,
    output logic             b0,
    output logic [CHUNK-1:0] d1,
    output logic             b1
);

    logic [CHUNK:0] r0;
    logic [CHUNK:0] r1;

    // The extra top bit of the widened difference is the borrow-out.
    assign r0 = {1'b0, a} - {1'b0, b};
    assign r1 = {1'b0, a} - {1'b0, b} - (CHUNK+1)'(1);

    assign d0 = r0[CHUNK-1:0];
    assign b0 = r0[CHUNK];
    assign d1 = r1[CHUNK-1:0];
    assign b1 = r1[CHUNK];

endmodule

// File: rtl/borrow_select_subtractor.sv
// Multi-cycle a - b - bin, one CHUNK-bit slice per RUN cycle, start/busy/done.
// Optional signed overflow output built when BSS_SIGNED_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last answer
// RUN   | one slice per cycle, borrow register selects d0/d1
// DONE  | one-cycle done pulse; start here begins the next op back-to-back
module borrow_select_subtractor
    import bss_pkg::*;
#(
    parameter int WIDTH = BSS_WIDTH,
    parameter int CHUNK = BSS_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef BSS_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_width(NCHUNK);

    state_t           state, state_nxt;
    logic             accept;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    idx;
    logic             borrow;
    logic             last;

    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK-1:0] d0, d1, d_sel;
    logic             b0, b1, b_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign last = (idx == IW'(NCHUNK - 1));

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IW'(i)) begin
                a_sl = a_q[i*CHUNK +: CHUNK];
                b_sl = b_q[i*CHUNK +: CHUNK];
            end
        end
    end

    borrow_select_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_sl),
        .b  (b_sl),
        .d0 (d0),
        .b0 (b0),
        .d1 (d1),
        .b1 (b1)
    );

    assign d_sel = borrow ? d1 : d0;
    assign b_sel = borrow ? b1 : b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef BSS_SIGNED_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            idx    <= '0;
        end else if (state == ST_RUN) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (idx == IW'(i)) diff[i*CHUNK +: CHUNK] <= d_sel;
            end
            borrow <= b_sel;
            idx    <= last ? '0 : idx + IW'(1);
            if (last) begin
                bout <= b_sel;
`ifdef BSS_SIGNED_OVF_EN
                // The MSB slice is being written this cycle, so use d_sel directly.
                ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                        (d_sel[CHUNK-1] != a_q[WIDTH-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_borrow_select_subtractor.sv
// Directed bench for borrow_select_subtractor; expected values hand-computed.
// Define BSS_SIGNED_OVF_EN to also exercise the ovf output.
module tb_borrow_select_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        bin;
    logic        busy, done;
    logic [15:0] diff;
    logic        bout;
`ifdef BSS_SIGNED_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;
    int edges, busy_n;

    borrow_select_subtractor #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef BSS_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation from a single start pulse; stops on done or after 20 edges.
    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                          output int n_edges, output int n_busy);
        @(posedge clk); #1;
        a = ia; b = ib; bin = ibin; start = 1'b1;
        n_edges = 0;
        n_busy  = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            n_edges++;
            if (busy) n_busy++;
            if (done) break;
        end
        chk("op_done", done, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        rst = 1'b0;

        // Reset in the middle of RUN clears everything without a clock edge.
        @(posedge clk); #1;
        a = 16'h00FF; b = 16'h0011; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy", busy, 1);
        chk("mid_partial", diff, 16'h000E);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_diff", diff, 0);
        chk("arst_bout", bout, 0);
        #1 rst = 1'b0;

        run_op(16'h1234, 16'h0234, 1'b0, edges, busy_n);
        chk("lat_edges", edges, 5);
        chk("lat_busy", busy_n, 4);
        chk("d1234_diff", diff, 16'h1000);
        chk("d1234_bout", bout, 0);
        @(posedge clk); #1;
        chk("hold_done", done, 0);
        chk("hold_diff", diff, 16'h1000);

        run_op(16'h0000, 16'h0001, 1'b0, edges, busy_n);
        chk("ripple_diff", diff, 16'hFFFF);
        chk("ripple_bout", bout, 1);

        run_op(16'h0000, 16'h0000, 1'b1, edges, busy_n);
        chk("bin_diff", diff, 16'hFFFF);
        chk("bin_bout", bout, 1);

        run_op(16'hFFFF, 16'hFFFF, 1'b0, edges, busy_n);
        chk("ffff_diff", diff, 16'h0000);
        chk("ffff_bout", bout, 0);

        run_op(16'h0005, 16'h0003, 1'b0, edges, busy_n);
        chk("small_diff", diff, 16'h0002);
        chk("small_bout", bout, 0);
`ifdef BSS_SIGNED_OVF_EN
        chk("small_ovf", ovf, 0);

        run_op(16'h8000, 16'h0001, 1'b0, edges, busy_n);
        chk("neg_diff", diff, 16'h7FFF);
        chk("neg_bout", bout, 0);
        chk("neg_ovf", ovf, 1);

        run_op(16'h7FFF, 16'hFFFF, 1'b0, edges, busy_n);
        chk("pos_diff", diff, 16'h8000);
        chk("pos_bout", bout, 1);
        chk("pos_ovf", ovf, 1);
`endif

        // start during RUN is ignored; start held in DONE begins the next op.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h0234; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("ign_busy", busy, 1);
        @(posedge clk); #1;
        chk("b2b_done1", done, 1);
        chk("b2b_diff1", diff, 16'h1000);
        chk("b2b_bout1", bout, 0);
        a = 16'h0010; b = 16'h0001; bin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy2", busy, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        chk("b2b_done2", done, 1);
        chk("b2b_diff2", diff, 16'h000F);
        chk("b2b_bout2", bout, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
